// File: rtl/bomb_defuse_checker_if.sv
// Handshake bundle between the game front end and the defuse checker.
// The master drives login/keypad strobes; the slave returns round status and result pulses.
interface bomb_defuse_checker_if;
  logic        login;
  logic [3:0]  user_id_in;
  logic [15:0] code;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        abort;
  logic [3:0]  user_id;
  logic        success;
  logic        fail;
  logic        busy;
  logic [7:0]  time_left;
  logic [2:0]  digit_count;

  modport master (
    output login, user_id_in, code, digit, digit_valid, abort,
    input  user_id, success, fail, busy, time_left, digit_count
  );

  modport slave (
    input  login, user_id_in, code, digit, digit_valid, abort,
    output user_id, success, fail, busy, time_left, digit_count
  );
endinterface

// File: rtl/bomb_defuse_checker.sv
// Game round: latch player and code at login, collect four digits against a countdown,
// then pulse success or fail for one cycle while holding the player ID for the level tracker.
module bomb_defuse_checker #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIME_LIMIT    = 30
) (
  input logic                  clk,
  input logic                  reset,
  bomb_defuse_checker_if.slave bus
);
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    user_id_q, user_id_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    digit_count_q, digit_count_d;
  logic [7:0]    time_left_q, time_left_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          success_q, success_d;
  logic          fail_q, fail_d;
  logic          tick_wrap;
  logic          timeout;

  assign tick_wrap = (tick_q == TICK_MAX);

  always_comb begin
    state_d       = state_q;
    user_id_d     = user_id_q;
    code_d        = code_q;
    buf_d         = buf_q;
    digit_count_d = digit_count_q;
    time_left_d   = time_left_q;
    tick_d        = tick_q;
    success_d     = 1'b0;
    fail_d        = 1'b0;
    timeout       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.login) begin
          user_id_d     = bus.user_id_in;
          code_d        = bus.code;
          buf_d         = '0;
          digit_count_d = '0;
          time_left_d   = 8'(TIME_LIMIT);
          tick_d        = '0;
          state_d       = S_ARMED;
        end
      end
      S_ARMED: begin
        timeout = tick_wrap && (time_left_q == 8'd1);
        // Abort beats timeout beats a digit; abort freezes the count and timer for inspection.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          tick_d      = '0;
          time_left_d = 8'd0;
          fail_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tick_d = tick_wrap ? '0 : tick_q + 1'b1;
          if (tick_wrap) begin
            time_left_d = time_left_q - 8'd1;
          end
          if (bus.digit_valid) begin
            for (int i = 0; i < 4; i++) begin
              if (digit_count_q[1:0] == 2'(i)) begin
                buf_d[15-4*i -: 4] = bus.digit;
              end
            end
            digit_count_d = digit_count_q + 3'd1;
            if (digit_count_q == 3'd3) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        success_d = (buf_q == code_q);
        fail_d    = (buf_q != code_q);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      user_id_q     <= '0;
      code_q        <= '0;
      buf_q         <= '0;
      digit_count_q <= '0;
      time_left_q   <= '0;
      tick_q        <= '0;
      success_q     <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      user_id_q     <= user_id_d;
      code_q        <= code_d;
      buf_q         <= buf_d;
      digit_count_q <= digit_count_d;
      time_left_q   <= time_left_d;
      tick_q        <= tick_d;
      success_q     <= success_d;
      fail_q        <= fail_d;
    end
  end

  assign bus.user_id     = user_id_q;
  assign bus.success     = success_q;
  assign bus.fail        = fail_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.time_left   = time_left_q;
  assign bus.digit_count = digit_count_q;
endmodule

// File: tb/tb_bomb_defuse_checker.sv
// Directed bench: stimulus pushes expected result pulses into a scoreboard queue,
// a negedge monitor pops and checks every success/fail pulse independently.
module tb_bomb_defuse_checker;
  localparam int TPS = 4;
  localparam int TL  = 3;

  typedef struct {
    bit         ok;
    logic [3:0] uid;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   e_cyc = 0;
  exp_t sb[$];
  exp_t m_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bomb_defuse_checker_if bus();

  bomb_defuse_checker #(.TICKS_PER_SEC(TPS), .TIME_LIMIT(TL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_login(input logic [3:0] uid, input logic [15:0] c);
    bus.login      = 1'b1;
    bus.user_id_in = uid;
    bus.code       = c;
    tick(1);
    bus.login = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick(1);
    bus.digit_valid = 1'b0;
  endtask

  task automatic expect_pulse(input bit ok, input logic [3:0] uid, input int at);
    exp_t e;
    e.ok  = ok;
    e.uid = uid;
    e.at  = at;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expectation in kind, player and cycle.
  always @(negedge clk) begin
    if (bus.success || bus.fail) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got success=%0b fail=%0b uid=%0h at cycle %0d, required no pulse",
                 bus.success, bus.fail, bus.user_id, cyc);
      end else begin
        m_e = sb.pop_front();
        if (bus.success !== m_e.ok || bus.fail !== !m_e.ok || bus.user_id !== m_e.uid ||
            cyc != m_e.at || bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL result: got success=%0b fail=%0b uid=%0h busy=%0b cycle=%0d, required success=%0b uid=%0h busy=0 cycle=%0d",
                   bus.success, bus.fail, bus.user_id, bus.busy, cyc, m_e.ok, m_e.uid, m_e.at);
        end else begin
          $display("ok   result: success=%0b uid=%0h cycle=%0d", bus.success, bus.user_id, cyc);
        end
      end
    end
  end

  initial begin
    bus.login       = 1'b0;
    bus.user_id_in  = '0;
    bus.code        = '0;
    bus.digit       = '0;
    bus.digit_valid = 1'b0;
    bus.abort       = 1'b0;
    tick(3);
    chk("rst_user_id", 32'(bus.user_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_time_left", 32'(bus.time_left), 32'h0);
    chk("rst_digit_count", 32'(bus.digit_count), 32'h0);
    chk("rst_pulses", 32'({bus.success, bus.fail}), 32'h0);
    reset = 1'b0;
    tick(1);

    // Reset in the middle of a round, then a clean restart.
    do_login(4'hA, 16'h1111);
    key(4'h1);
    key(4'h2);
    chk("mid_digit_count", 32'(bus.digit_count), 32'h2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_user_id", 32'(bus.user_id), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_time_left", 32'(bus.time_left), 32'h0);
    chk("mid_rst_digit_count", 32'(bus.digit_count), 32'h0);
    chk("mid_rst_pulses", 32'({bus.success, bus.fail}), 32'h0);
    do_login(4'h3, 16'h0000);
    chk("relogin_digit_count", 32'(bus.digit_count), 32'h0);
    chk("relogin_busy", 32'(bus.busy), 32'h1);
    chk("relogin_time_left", 32'(bus.time_left), 32'(TL));
    chk("relogin_user_id", 32'(bus.user_id), 32'h3);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;

    // Correct entry.
    do_login(4'hC, 16'h1234);
    key(4'h1);
    key(4'h2);
    key(4'h3);
    key(4'h4);
    chk("ok_digit_count", 32'(bus.digit_count), 32'h4);
    chk("ok_busy_check", 32'(bus.busy), 32'h1);
    expect_pulse(1'b1, 4'hC, cyc + 1);
    tick(1);
    chk("ok_busy_pulse", 32'(bus.busy), 32'h0);
    tick(10);
    chk("ok_user_id_held", 32'(bus.user_id), 32'hC);

    // Wrong entry, then a login during the result pulse.
    do_login(4'h7, 16'h1234);
    key(4'h1);
    key(4'h2);
    key(4'h3);
    key(4'h5);
    expect_pulse(1'b0, 4'h7, cyc + 1);
    tick(1);
    do_login(4'h9, 16'hABCD);
    chk("b2b_busy", 32'(bus.busy), 32'h1);
    chk("b2b_user_id", 32'(bus.user_id), 32'h9);
    chk("b2b_time_left", 32'(bus.time_left), 32'(TL));
    chk("b2b_digit_count", 32'(bus.digit_count), 32'h0);
    key(4'hA);
    key(4'hB);
    key(4'hC);
    key(4'hD);
    expect_pulse(1'b1, 4'h9, cyc + 1);
    tick(2);

    // Timeout with no digits.
    do_login(4'h6, 16'h0F0F);
    e_cyc = cyc;
    expect_pulse(1'b0, 4'h6, e_cyc + 4 * TL);
    chk("to_time_left_3", 32'(bus.time_left), 32'h3);
    tick(4);
    chk("to_time_left_2", 32'(bus.time_left), 32'h2);
    tick(4);
    chk("to_time_left_1", 32'(bus.time_left), 32'h1);
    tick(4);
    chk("to_time_left_0", 32'(bus.time_left), 32'h0);
    chk("to_busy", 32'(bus.busy), 32'h0);
    tick(1);

    // Fourth digit lands on the final wrap: timeout wins, digit dropped.
    do_login(4'h2, 16'h4321);
    e_cyc = cyc;
    key(4'h4);
    key(4'h3);
    key(4'h2);
    tick(8);
    expect_pulse(1'b0, 4'h2, e_cyc + 4 * TL);
    key(4'h1);
    chk("coll_digit_count", 32'(bus.digit_count), 32'h3);
    chk("coll_busy", 32'(bus.busy), 32'h0);
    chk("coll_time_left", 32'(bus.time_left), 32'h0);
    tick(1);

    // Abort after two digits; digits in IDLE are ignored.
    do_login(4'h5, 16'h5555);
    key(4'h5);
    key(4'h5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_digit_count", 32'(bus.digit_count), 32'h2);
    chk("abort_time_left", 32'(bus.time_left), 32'h3);
    key(4'h7);
    chk("idle_digit_count", 32'(bus.digit_count), 32'h2);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Login while armed is ignored; the round completes with the first code.
    do_login(4'h8, 16'h8888);
    do_login(4'h1, 16'h1111);
    chk("armed_login_user_id", 32'(bus.user_id), 32'h8);
    key(4'h8);
    key(4'h8);
    key(4'h8);
    key(4'h8);
    expect_pulse(1'b1, 4'h8, cyc + 1);
    tick(5);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bomb_defuse_checker.md
# bomb_defuse_checker

Upstream game-round stage for the per-user level tracker. It latches a player ID and target code at login, collects four keypad digits under a countdown, and compares them with the latched code. It then emits a one-cycle `success` or `fail` pulse. The player ID is held stable on `user_id` through the pulse and until the next login, so the downstream level tracker can sample `user_id` and `success` together.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per countdown second.
- `TIME_LIMIT`, default 30: seconds allowed per round; range 1..255.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `login` in 1: start-round strobe; samples `user_id_in` and `code`.
- `user_id_in` in 4: player ID to latch at login.
- `code` in 16: target code; digit 0 in [15:12], digit 3 in [3:0].
- `digit` in 4: keypad digit.
- `digit_valid` in 1: one-cycle strobe qualifying `digit`.
- `abort` in 1: cancels the active round without a result.
- `user_id` out 4: latched player ID.
- `success` out 1: one-cycle pulse when the code matches.
- `fail` out 1: one-cycle pulse on wrong code or timeout.
- `busy` out 1: high in ARMED and CHECK.
- `time_left` out 8: remaining seconds.
- `digit_count` out 3: digits accepted this round (0..4).

## Operation
- **States:**
  - IDLE: waits for `login`.
  - ARMED: collects digits.
  - CHECK: compares one cycle, then returns to IDLE.
- **IDLE, `login`=1:**
  - latch `user_id_in` into `user_id`, and `code` into an internal register;
  - clear the entry buffer and `digit_count`;
  - set `time_left`=TIME_LIMIT and clear the tick counter;
  - go to ARMED.
  - `digit_valid` and `abort` are ignored in IDLE.
- **ARMED:**
  - Each `digit_valid` writes `digit` to buffer slot `digit_count` and increments `digit_count`.
  - The 4th accepted digit moves the FSM to CHECK.
  - `login` is ignored while ARMED.
- **Countdown:**
  - The tick counter runs only in ARMED and wraps at TICKS_PER_SEC-1.
  - Each wrap decrements `time_left`.
  - If `time_left` is 1 at a wrap, the FSM goes to IDLE with `time_left`=0 and `fail` pulses.
- **CHECK:** compare the 16-bit buffer to the latched code.
  - Equal: `success`=1 for exactly one cycle.
  - Not equal: `fail`=1 for exactly one cycle.
  - In either case, go to IDLE.
- **abort in ARMED:** go to IDLE with no pulse; `digit_count` and `time_left` keep their values.
- **Simultaneous events, priority order:** `reset` > `abort` > timeout > `digit_valid`.
  - A timeout in the same cycle as the 4th digit produces `fail`; the digit is dropped.
- `success` and `fail` are never high together.
- `user_id` holds its value through and after the result until the next accepted `login`.
- `reset` at any time, including mid-round:
  - state IDLE;
  - `user_id`, `success`, `fail`, `busy`, `time_left`, `digit_count`, buffer, code register and tick counter all 0;
  - no pulse is emitted.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `login` sampled at edge E: `busy`=1, `user_id` valid and `time_left`=TIME_LIMIT from the cycle after E.
- 4th `digit_valid` sampled at edge N: state is CHECK after N, and `digit_count`=4. At edge N+1 the FSM enters IDLE and `success`/`fail` goes high for the single cycle following N+1. `busy` is low in that same cycle.
- Timeout: `fail` is high in the cycle after the final tick wrap; `busy` falls at the same edge.
- Back-to-back rounds: a `login` is accepted in the same cycle the result pulse is high, since the FSM is already in IDLE.
- One `digit_valid` is accepted per cycle; consecutive-cycle strobes are all accepted.

## Test plan
Parameters for all scenarios: `TICKS_PER_SEC`=4, `TIME_LIMIT`=3.

- Reset mid-round: `login`, then 2 digits, then `reset` → all outputs 0; a following `login` starts cleanly with `digit_count`=0.
- Correct entry: `login`, `user_id_in`=4'hC, `code`=16'h1234; digits 1,2,3,4 on consecutive cycles → `success` high exactly 1 cycle, 2 cycles after digit 4; `fail`=0; `user_id`=4'hC still held 10 cycles later.
- Wrong entry: `code`=16'h1234; digits 1,2,3,5 → `fail` single pulse, `success`=0, `busy`=0 from the pulse cycle.
- Timeout: `login`, then no digits → `time_left` steps 3, 2, 1 every 4 cycles; `fail` pulses 12 cycles after `busy` rises, and `time_left`=0.
- Timeout/digit collision: 3 digits entered, 4th `digit_valid` driven in the final-wrap cycle → `fail`, not `success`.
- Abort and ignored inputs:
  - `abort` after 2 digits → IDLE, no pulse.
  - `digit_valid` in IDLE → `digit_count` unchanged.
  - `login` during ARMED with a new `user_id_in` → `user_id` unchanged.
